// File: rtl/armsim_rf_pkg.sv
// Shared defaults and types for the parametrised ARM-style register file.
// Read ports, top-level array and bench all pull sizing from here.
package armsim_rf_pkg;

    localparam int WIDTH_D     = 32;
    localparam int NUM_REGS_D  = 16;
    localparam int AW_D        = $clog2(NUM_REGS_D);
    localparam int PC_IDX_D    = 15;
    localparam int PC_OFFSET_D = 8;
    localparam int PC_STEP_D   = 4;
    localparam int BYPASS_D    = 1;

    typedef logic [AW_D-1:0] reg_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register mux, write-first bypass,
// and the PC look-ahead offset.
module rf_read_port
    import armsim_rf_pkg::*;
#(
    parameter int WIDTH     = WIDTH_D,
    parameter int NUM_REGS  = NUM_REGS_D,
    parameter int AW        = AW_D,
    parameter int PC_IDX    = PC_IDX_D,
    parameter int PC_OFFSET = PC_OFFSET_D,
    parameter int BYPASS    = BYPASS_D
) (
    input  logic [AW-1:0]                     addr,
    input  logic                              wrEn,
    input  logic [AW-1:0]                     wrAddr,
    input  logic [WIDTH-1:0]                  wrData,
    input  logic [NUM_REGS-1:0][WIDTH-1:0]    regs,
    input  logic [WIDTH-1:0]                  pc,
    output logic [WIDTH-1:0]                  data
);

    logic hit;
    logic isPc;

    assign hit  = (BYPASS != 0) && wrEn && (addr == wrAddr);
    assign isPc = (addr == AW'(PC_IDX));

    // wrData arrives already masked when it targets the PC
    always_comb begin
        data = regs[addr];
        if (isPc) begin
            data = (hit ? wrData : pc) + WIDTH'(PC_OFFSET);
        end else if (hit) begin
            data = wrData;
        end
    end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: three read ports, one write port,
// integrated PC with fetch increment, and a pending-load scoreboard.
module register_file_param
    import armsim_rf_pkg::*;
#(
    parameter int WIDTH     = WIDTH_D,
    parameter int NUM_REGS  = NUM_REGS_D,
    parameter int AW        = $clog2(NUM_REGS),
    parameter int PC_IDX    = PC_IDX_D,
    parameter int PC_OFFSET = PC_OFFSET_D,
    parameter int PC_STEP   = PC_STEP_D,
    parameter int BYPASS    = BYPASS_D
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             RW,
    input  logic [AW-1:0]    writeAddress,
    input  logic [WIDTH-1:0] inputData,
    input  logic [AW-1:0]    addressA,
    input  logic [AW-1:0]    addressB,
    input  logic [AW-1:0]    addressC,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    input  logic             PC_LD,
    output logic [WIDTH-1:0] pcOut,
    input  logic             MARK,
    input  logic [AW-1:0]    markAddress,
    output logic             busyA,
    output logic             busyB,
    output logic             busyC
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][WIDTH-1:0] regsNext;
    logic [NUM_REGS-1:0]            busy;
    logic [NUM_REGS-1:0]            busyNext;
    logic                           wrEn;
    logic                           wrIsPc;
    logic [WIDTH-1:0]               wrData;
    logic [WIDTH-1:0]               pc;

    assign wrEn   = ~RW;
    assign wrIsPc = (writeAddress == AW'(PC_IDX));
    assign wrData = wrIsPc ? {inputData[WIDTH-1:2], 2'b00}
                           : inputData;
    assign pc     = regs[PC_IDX];

    // Later assignments win: write beats PC_LD, MARK beats write-clear
    always_comb begin
        regsNext = regs;
        busyNext = busy;
        if (PC_LD) begin
            regsNext[PC_IDX] = pc + WIDTH'(PC_STEP);
        end
        if (wrEn) begin
            regsNext[writeAddress] = wrData;
            busyNext[writeAddress] = 1'b0;
        end
        if (MARK) begin
            busyNext[markAddress] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            regs <= '0;
            busy <= '0;
        end else begin
            regs <= regsNext;
            busy <= busyNext;
        end
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .PC_IDX   (PC_IDX),
        .PC_OFFSET(PC_OFFSET),
        .BYPASS   (BYPASS)
    ) portA (
        .addr  (addressA),
        .wrEn  (wrEn),
        .wrAddr(writeAddress),
        .wrData(wrData),
        .regs  (regs),
        .pc    (pc),
        .data  (outA)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .PC_IDX   (PC_IDX),
        .PC_OFFSET(PC_OFFSET),
        .BYPASS   (BYPASS)
    ) portB (
        .addr  (addressB),
        .wrEn  (wrEn),
        .wrAddr(writeAddress),
        .wrData(wrData),
        .regs  (regs),
        .pc    (pc),
        .data  (outB)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .PC_IDX   (PC_IDX),
        .PC_OFFSET(PC_OFFSET),
        .BYPASS   (BYPASS)
    ) portC (
        .addr  (addressC),
        .wrEn  (wrEn),
        .wrAddr(writeAddress),
        .wrData(wrData),
        .regs  (regs),
        .pc    (pc),
        .data  (outC)
    );

    assign pcOut = pc;
    assign busyA = busy[addressA];
    assign busyB = busy[addressB];
    assign busyC = busy[addressC];

endmodule
